// File: rtl/mdiv_iter_if.sv
// Operand/result handshake bundle for the iterative mantissa divider.
// master drives operands and out_ready; slave returns in_ready and the rounded result.
interface mdiv_iter_if #(
  parameter int WIDTH = 23
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] m1;
  logic [WIDTH-1:0] m2;
  logic [1:0]       round_mode;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] m3;
  logic             decrement_exponent;
  logic             inexact;

  modport master (
    output in_valid, m1, m2, round_mode, sign, out_ready,
    input  in_ready, out_valid, m3, decrement_exponent, inexact
  );

  modport slave (
    input  in_valid, m1, m2, round_mode, sign, out_ready,
    output in_ready, out_valid, m3, decrement_exponent, inexact
  );
endinterface

// File: rtl/mdiv_iter.sv
// Restoring mantissa divider, one quotient bit per cycle; result after WIDTH+4 edges from accept.
// Accepts only in IDLE; holds the result in DONE until out_ready, so no new operands overlap.
module mdiv_iter #(
  parameter int WIDTH = 23
) (
  input  logic       clk,
  input  logic       reset,
  mdiv_iter_if.slave bus
);
  localparam int N  = WIDTH + 3;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH+1:0] r_rem;
  logic [WIDTH+1:0] r_div;
  logic [N-1:0]     r_q;
  logic [1:0]       r_mode;
  logic             r_sign;
  logic [WIDTH-1:0] r_m3;
  logic             r_dec;
  logic             r_inx;

  logic             w_accept;
  logic             w_ge;
  logic [WIDTH+1:0] w_sub;
  logic [WIDTH+1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_mant;
  logic             w_rbit;
  logic             w_sticky;
  logic             w_dec;
  logic             w_inc;
  logic [WIDTH-1:0] w_m3_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // R < 2D always holds, so the shifted partial remainder never loses its MSB.
  always_comb begin
    w_ge      = (r_rem >= r_div);
    w_sub     = r_rem - r_div;
    w_rem_nxt = (w_ge ? w_sub : r_rem) << 1;
  end

  always_comb begin
    w_mant   = '0;
    w_rbit   = 1'b0;
    w_sticky = 1'b0;
    w_dec    = 1'b0;
    w_inc    = 1'b0;
    if (r_q[N-1]) begin
      w_mant   = r_q[N-2:2];
      w_rbit   = r_q[1];
      w_sticky = r_q[0] | (|r_rem);
      w_dec    = 1'b0;
    end else begin
      w_mant   = r_q[N-3:1];
      w_rbit   = r_q[0];
      w_sticky = |r_rem;
      w_dec    = 1'b1;
    end
    case (r_mode)
      2'b00:   w_inc = w_rbit & (w_sticky | w_mant[0]);
      2'b01:   w_inc = 1'b0;
      2'b10:   w_inc = ~r_sign & (w_rbit | w_sticky);
      default: w_inc = r_sign & (w_rbit | w_sticky);
    endcase
    // Normalized quotient tops out at 2-2^-WIDTH, so the increment cannot carry out.
    w_m3_nxt = w_mant + {{(WIDTH-1){1'b0}}, w_inc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_q    <= '0;
      r_mode <= '0;
      r_sign <= 1'b0;
      r_m3   <= '0;
      r_dec  <= 1'b0;
      r_inx  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem  <= {2'b01, bus.m1};
            r_div  <= {2'b01, bus.m2};
            r_mode <= bus.round_mode;
            r_sign <= bus.sign;
            r_q    <= '0;
            r_cnt  <= CW'(N - 1);
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[N-2:0], w_ge};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ROUND: begin
          r_m3  <= w_m3_nxt;
          r_dec <= w_dec;
          r_inx <= w_rbit | w_sticky;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready           = (r_state == S_IDLE);
  assign bus.out_valid          = (r_state == S_DONE);
  assign bus.m3                 = r_m3;
  assign bus.decrement_exponent = r_dec;
  assign bus.inexact            = r_inx;
endmodule
